// File: rtl/citadel_key_presenter.sv
// Initiator side of the Sentinel gate key interface: presents a key, samples the
// gate's authorized status after a settle window, retries with backoff, locks out.
module citadel_key_presenter #(
    parameter int unsigned SETTLE_CYCLES  = 3,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned BACKOFF_CYCLES = 4,
    parameter logic [7:0]  IDLE_KEY       = 8'h00,
    localparam int unsigned AW = $clog2(MAX_RETRIES + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [7:0]    i_key_value,
    input  logic          i_auth_in,
    input  logic          i_release,
    input  logic          i_abort,
    input  logic          i_clear,
    output logic [7:0]    o_key_out,
    output logic          o_busy,
    output logic          o_granted,
    output logic          o_denied,
    output logic          o_lost,
    output logic [AW-1:0] o_attempts
);

    localparam int unsigned CMAX = (SETTLE_CYCLES > BACKOFF_CYCLES) ? SETTLE_CYCLES : BACKOFF_CYCLES;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF_CYCLES - 1);
    localparam logic [AW-1:0] ATT_LIMIT    = AW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_BACKOFF,
        S_GRANTED,
        S_LOCKOUT
    } state_t;

    state_t        r_state;
    logic [7:0]    r_key;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_attempts;
    logic [7:0]    r_key_out;
    logic          r_busy;
    logic          r_granted;
    logic          r_denied;
    logic          r_lost;
    logic [AW-1:0] w_att_inc;
    logic          w_abortable;

    assign w_att_inc   = r_attempts + AW'(1);
    assign w_abortable = (r_state == S_DRIVE) || (r_state == S_SAMPLE) ||
                         (r_state == S_BACKOFF) || (r_state == S_GRANTED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_key      <= IDLE_KEY;
            r_cnt      <= '0;
            r_attempts <= '0;
            r_key_out  <= IDLE_KEY;
            r_busy     <= 1'b0;
            r_granted  <= 1'b0;
            r_denied   <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            // Abort outranks everything else in the states it applies to.
            if (i_abort && w_abortable) begin
                r_state   <= S_IDLE;
                r_key_out <= IDLE_KEY;
                r_busy    <= 1'b0;
                r_granted <= 1'b0;
                r_cnt     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_key      <= i_key_value;
                            r_key_out  <= i_key_value;
                            r_attempts <= '0;
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        if (r_cnt == SETTLE_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_SAMPLE: begin
                        if (i_auth_in) begin
                            r_busy    <= 1'b0;
                            r_granted <= 1'b1;
                            r_state   <= S_GRANTED;
                        end else begin
                            r_attempts <= w_att_inc;
                            r_key_out  <= IDLE_KEY;
                            r_cnt      <= '0;
                            if (w_att_inc == ATT_LIMIT) begin
                                r_busy   <= 1'b0;
                                r_denied <= 1'b1;
                                r_state  <= S_LOCKOUT;
                            end else begin
                                r_state <= S_BACKOFF;
                            end
                        end
                    end
                    S_BACKOFF: begin
                        if (r_cnt == BACKOFF_LAST) begin
                            r_cnt     <= '0;
                            r_key_out <= r_key;
                            r_state   <= S_DRIVE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_GRANTED: begin
                        if (i_release || !i_auth_in) begin
                            r_lost    <= !i_release;
                            r_granted <= 1'b0;
                            r_key_out <= IDLE_KEY;
                            r_state   <= S_IDLE;
                        end
                    end
                    S_LOCKOUT: begin
                        if (i_clear) begin
                            r_attempts <= '0;
                            r_denied   <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_key_out <= IDLE_KEY;
                        r_busy    <= 1'b0;
                        r_granted <= 1'b0;
                        r_denied  <= 1'b0;
                        r_cnt     <= '0;
                    end
                endcase
            end
        end
    end

    assign o_key_out  = r_key_out;
    assign o_busy     = r_busy;
    assign o_granted  = r_granted;
    assign o_denied   = r_denied;
    assign o_lost     = r_lost;
    assign o_attempts = r_attempts;

endmodule
